// File: rtl/seg7_pkg.sv
// Shared types and active-high segment patterns for the 4-digit scanner.
// Bit order is {g,f,e,d,c,b,a}; the top inverts for the common-anode pins.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-high segment decoder.
// Non-decimal codes render a dash so corrupt results are visible.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg
);

    // Plain lookup; codes 10..15 fall to the dash.
    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode scanner. A result is staged in
// pending and copied to shadow only at the frame wrap, so a frame never
// mixes two values. Each slot opens with a dark gap to hide ghosting.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 50,
    parameter int BLANK_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] bcd_in,
    input  logic        bcd_load,
    input  logic        blank_lz,
    output logic [6:0]  seg_n,
    output logic [3:0]  an_n,
    output logic        frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [CW-1:0]               cnt;
    logic [1:0]                  idx;
    bcd_t [NUM_DIGITS-1:0]       pending;
    bcd_t [NUM_DIGITS-1:0]       shadow;
    logic [NUM_DIGITS-1:0][6:0]  dig_seg;
    logic [NUM_DIGITS-1:0]       lz_dark;
    logic                        slot_end;
    logic                        commit;
    logic [3:0]                  an_nxt;
    logic [6:0]                  seg_nxt;

    assign slot_end = (cnt == CNT_LAST);
    assign commit   = en && slot_end && (idx == 2'd3);

    // One decoder per digit of the shadow value; the active slot picks one.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        bcd_to_seg7 u_dec (
            .digit (shadow[g]),
            .seg   (dig_seg[g])
        );
    end

    // Leading-zero run from the thousands digit downward; ones never blanks.
    always_comb begin
        logic run;
        lz_dark = '0;
        run     = blank_lz;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run        = run && (shadow[k] == 4'd0);
            lz_dark[k] = run;
        end
    end

    // Next pin values: dark during the blanking gap, else selected digit.
    always_comb begin
        an_nxt  = 4'hF;
        seg_nxt = 7'h7F;
        if (cnt >= BLANK_END) begin
            an_nxt  = ~(4'b0001 << idx);
            seg_nxt = ~(lz_dark[idx] ? SEG_OFF : dig_seg[idx]);
        end
    end

    // Pending buffer: every load overwrites, last one before commit wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (bcd_load) begin
            pending <= bcd_in;
        end
    end

    // Slot counter and digit index; disable parks both at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (!en) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Shadow tracks pending while disabled so re-enable is up to date;
    // at the frame wrap a same-cycle load bypasses pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (!en) begin
            shadow <= pending;
        end else if (commit) begin
            shadow <= bcd_load ? bcd_in : pending;
        end
    end

    // Registered pins and frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n       <= 4'hF;
            seg_n      <= 7'h7F;
            frame_tick <= 1'b0;
        end else if (!en) begin
            an_n       <= 4'hF;
            seg_n      <= 7'h7F;
            frame_tick <= 1'b0;
        end else begin
            an_n       <= an_nxt;
            seg_n      <= seg_nxt;
            frame_tick <= commit;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random traffic,
// every cycle compared against a frame-position model of the display.
module tb_seg7_scan_driver;

    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        bcd_load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_tick;

    int vectors = 0;
    int miscompares = 0;

    // Model state: time since scan (re)start, buffers, expected pins.
    int          m_t = 0;
    logic [15:0] m_pending = '0;
    logic [15:0] m_shadow = '0;
    logic [3:0]  exp_an = 4'hF;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_tick = 1'b0;

    seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .bcd_in     (bcd_in),
        .bcd_load   (bcd_load),
        .blank_lz   (blank_lz),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_on(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // What the pins should show for a given position within the frame.
    task automatic model_drive(input int t, input logic [15:0] sh, input logic blz);
        int pos, d, c;
        logic [3:0] dig;
        pos = t % FRAME;
        d   = pos / SCAN_DIV;
        c   = pos % SCAN_DIV;
        if (c < BLANK_CYC) begin
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
        end else begin
            exp_an = 4'(~(32'd1 << d));
            dig    = 4'((sh >> (4 * d)) & 16'hF);
            if (blz && d > 0 && (sh >> (4 * d)) == 16'h0)
                exp_seg = 7'h7F;
            else
                exp_seg = ~seg_on(dig);
        end
    endtask

    task automatic check(input string tag);
        vectors++;
        assert (an_n === exp_an) else begin
            miscompares++;
            $error("FAIL %s an_n got %h want %h (t=%0d)", tag, an_n, exp_an, m_t);
        end
        vectors++;
        assert (seg_n === exp_seg) else begin
            miscompares++;
            $error("FAIL %s seg_n got %b want %b (t=%0d)", tag, seg_n, exp_seg, m_t);
        end
        vectors++;
        assert (frame_tick === exp_tick) else begin
            miscompares++;
            $error("FAIL %s frame_tick got %b want %b (t=%0d)", tag, frame_tick, exp_tick, m_t);
        end
    endtask

    // One clock with the given inputs; model advances, then pins compared.
    task automatic step(input logic e, input logic ld, input logic [15:0] b,
                        input logic blz, input string tag);
        logic commit;
        en = e; bcd_load = ld; bcd_in = b; blank_lz = blz;
        @(posedge clk);
        if (e) begin
            model_drive(m_t, m_shadow, blz);
            commit   = ((m_t % FRAME) == FRAME - 1);
            exp_tick = commit;
            if (commit) m_shadow = ld ? b : m_pending;
            m_t++;
        end else begin
            exp_an   = 4'hF;
            exp_seg  = 7'h7F;
            exp_tick = 1'b0;
            m_shadow = m_pending;
            m_t      = 0;
        end
        if (ld) m_pending = b;
        #1;
        check(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_t = 0; m_pending = '0; m_shadow = '0;
        exp_an = 4'hF; exp_seg = 7'h7F; exp_tick = 1'b0;
        check("reset_async");
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_hold");
        end
        rst_n = 1'b1;
    endtask

    // Idle-clock until the model sits at a given frame position (bounded).
    task automatic run_to(input int pos, input logic blz, input string tag);
        for (int k = 0; k < 2 * FRAME && (m_t % FRAME) != pos; k++)
            step(1'b1, 1'b0, 16'h0, blz, tag);
    endtask

    initial begin
        logic        r_ld, r_en, r_blz;
        logic [15:0] r_b;

        #2;
        do_reset();

        // Two frames after reset: "0" on ones, anodes E,D,B,7, ticks.
        repeat (2 * FRAME) step(1'b1, 1'b0, 16'h0, 1'b0, "scan_zero");

        // Mid-frame load at idx=1 must wait for the frame wrap.
        run_to(SCAN_DIV + 3, 1'b0, "align1");
        step(1'b1, 1'b1, 16'h1234, 1'b0, "load_1234");
        repeat (2 * FRAME) step(1'b1, 1'b0, 16'h0, 1'b0, "show_1234");

        // Two loads then a commit-cycle load; last wins, leading zeros dark.
        run_to(1, 1'b1, "align2");
        step(1'b1, 1'b1, 16'h0005, 1'b1, "load_0005");
        repeat (5) step(1'b1, 1'b0, 16'h0, 1'b1, "gap");
        step(1'b1, 1'b1, 16'h0987, 1'b1, "load_0987");
        run_to(FRAME - 1, 1'b1, "align3");
        step(1'b1, 1'b1, 16'h0042, 1'b1, "bypass_0042");
        repeat (FRAME) step(1'b1, 1'b0, 16'h0, 1'b1, "show_0042");

        // Non-decimal digit renders a dash; zero thousands stays dark.
        step(1'b1, 1'b1, 16'h0C07, 1'b1, "load_0c07");
        repeat (2 * FRAME) step(1'b1, 1'b0, 16'h0, 1'b1, "show_dash");

        // Disable mid-slot while loading; re-enable shows 9999 at once.
        run_to(SCAN_DIV + 4, 1'b0, "align4");
        step(1'b0, 1'b1, 16'h9999, 1'b0, "dis_load");
        repeat (9) step(1'b0, 1'b0, 16'h0, 1'b0, "disabled");
        repeat (FRAME + 4) step(1'b1, 1'b0, 16'h0, 1'b0, "reenable");

        // Async reset at idx=2, cnt=5.
        run_to(2 * SCAN_DIV + 5, 1'b0, "align5");
        #2;
        do_reset();
        repeat (FRAME + 2) step(1'b1, 1'b0, 16'h0, 1'b0, "post_reset");

        // Random traffic.
        r_blz = 1'b0;
        for (int i = 0; i < 600; i++) begin
            r_ld = ($urandom_range(0, 7) == 0);
            r_b  = 16'($urandom());
            r_en = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 49) == 0) r_blz = ~r_blz;
            if ($urandom_range(0, 2) == 0) r_b[15:8] = 8'h00;
            step(r_en, r_ld, r_b, r_blz, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed 4-digit seven-segment scanner downstream of the reaction-time benchmark. Captures a 16-bit packed BCD result (ones..thousands) and commits it only at frame boundaries, so the display never tears. Drives active-low common-anode digit selects and segment lines with an inter-digit blanking gap against ghosting. Optional leading-zero suppression.

## Interface
- SCAN_DIV, default 50: clk cycles per digit slot; 1 kHz digit rate at the 50 kHz system clock; legal ≥ 4.
- BLANK_CYC, default 4: cycles at the start of each slot with all anodes off; legal 1..SCAN_DIV-2.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable; low forces display dark.
- bcd_in  in  16  {thousands, hundreds, tens, ones}, 4 bits each.
- bcd_load  in  1  one-cycle strobe; bcd_in captured into pending buffer.
- blank_lz  in  1  suppress leading zeros (digits 3..1).
- seg_n  out  7  {g,f,e,d,c,b,a}, active-low, registered.
- an_n  out  4  digit enables, active-low, an_n[0] = ones, registered.
- frame_tick  out  1  one-cycle pulse when the slot index wraps 3→0.

## Operation
- Registers: slot counter cnt (0..SCAN_DIV-1), digit index idx (0..3), pending[15:0], shadow[15:0].
- Reset: cnt=0, idx=0, pending=0, shadow=0, an_n=4'hF, seg_n=7'h7F, frame_tick=0.
- Load: bcd_load → pending <= bcd_in next edge; last load before commit wins.
- Commit: on the cycle cnt=SCAN_DIV-1 and idx=3, shadow <= (bcd_load ? bcd_in : pending); same-cycle load bypasses pending.
- Scan: cnt increments each cycle while en; at SCAN_DIV-1 wraps to 0 and idx increments mod 4.
- Drive: cnt < BLANK_CYC → an_n=4'hF, seg_n=7'h7F; else an_n = ~(1<<idx), seg_n = ~decode(shadow digit idx).
- Decode: 0-9 standard patterns; 10-15 render dash (g only, seg_n=7'b0111111).
- Leading-zero blank: digit k (k=3..1) is dark (seg_n=7'h7F, anode still driven) when blank_lz and digits 3..k of shadow are all 0. Digit 0 never blanked; 0000 shows "0".
- en low: cnt=0, idx=0 synchronously, an_n=4'hF, seg_n=7'h7F, frame_tick=0; shadow <= pending every cycle, so re-enable shows the latest value immediately.

## Timing
- Outputs registered: one-cycle latency from cnt/idx/shadow to pins.
- Frame = 4·SCAN_DIV cycles; each digit lit SCAN_DIV-BLANK_CYC cycles per frame.
- frame_tick high the cycle after the commit edge, concurrent with shadow update.
- Load-to-display latency: ≤ 4·SCAN_DIV + 1 cycles.
- Reset mid-frame: outputs go dark asynchronously; scanning restarts at idx=0, cnt=0 on first edge after release.
- blank_lz and en are sampled each cycle (not frame-aligned).

## Structure
- Package seg7_pkg: digit-pattern constants SEG_0..SEG_9, SEG_DASH, SEG_OFF, and the BCD digit typedef (4-bit).
- Sub-module bcd_to_seg7: combinational 4-bit → 7-bit active-high decoder; the top inverts and registers.
- Top holds counters, pending/shadow buffers, blank logic, output registers.

## Test plan
- Bench params SCAN_DIV=8, BLANK_CYC=2.
- Reset: hold rst_n=0 → an_n=4'hF, seg_n=7'h7F; release with en=1, no load → digit 0 shows "0" (seg_n=7'b1000000) at cnt≥2; an_n cycles E,D,B,7; frame_tick every 32 cycles.
- Load 16'h1234 mid-frame at idx=1 → no digit changes until frame_tick; following frame shows 4,3,2,1 on an_n[0..3].
- Two loads (16'h0005, then 16'h0987) in one frame, plus bcd_load with 16'h0042 on the commit cycle → displayed value 0042; blank_lz=1 → digits 3,2 dark, tens "4", ones "2".
- Digit value 4'hC in bcd_in → that slot shows dash 7'b0111111.
- en=0 for 10 cycles mid-slot while loading 16'h9999 → all dark, idx=0; en=1 → 9 on an_n[0] after BLANK_CYC cycles (+1 register cycle).
- Async reset asserted at idx=2, cnt=5 → outputs dark same cycle; after release scan restarts at idx=0, shadow=0.
